spi_ram_burst: RTL and testbench
================================

// Module: spi_ram_burst
// PURPOSE
//  SPI-slave-fronted single-port RAM with command decode and burst auto-increment; successor to the SPI+RAM top.
//  Frame = 8-bit command, ADDR_W-bit start address, then any number of DATA_W-bit words until SS_n rises.
//  Generalises address/data width and depth; adds burst read/write, address wrap and framing-error reporting.
// PARAMETERS
//  ADDR_W   8           address field width in bits (as sent on MOSI)
//  DATA_W   8           word width in bits; must be >= 2
//  DEPTH    256         words of storage; <= 2**ADDR_W; pointer wraps DEPTH-1 -> 0
// PORTS
//  clk        in   1  single clock; MOSI sampled and MISO updated on rising edge
//  rst        in   1  synchronous, active-high reset
//  SS_n       in   1  slave select, active low; frame is active while low
//  MOSI       in   1  serial in, MSB first
//  MISO       out  1  serial out, MSB first; 0 whenever not in RD_DATA
//  busy       out  1  1 while state != IDLE
//  frame_err  out  1  one-cycle pulse on bad command or SS_n rise mid-field
// BEHAVIOUR
//  Reset: state IDLE, bit_cnt 0, ptr 0, shifts 0, MISO 0, busy 0, frame_err 0; memory contents untouched.
//  SS_n high on any edge (any state) -> IDLE next cycle; MISO 0 from that cycle. Highest priority after rst.
//  States: IDLE, CMD, ADDR, WR_DATA, RD_DUMMY, RD_DATA, IGNORE.
//  IDLE: on edge with SS_n=0, MOSI captured as cmd bit 7 -> CMD (bit_cnt=1). Cycle of first low SS_n = cycle 0.
//  CMD: 8th bit (cycle 7) completes cmd. 0x02 -> ADDR(write), 0x03 -> ADDR(read), other -> IGNORE + frame_err.
//  ADDR: ADDR_W bits; ptr <= assembled address mod DEPTH on last bit -> WR_DATA or RD_DUMMY.
//  WR_DATA: shift in DATA_W bits; on last bit mem[ptr] <= {shift,MOSI} that edge, ptr <= ptr+1 (wrap). Unlimited words.
//  RD_DUMMY: exactly 2 cycles, MOSI ignored, MISO 0. D0: rd_q <= mem[ptr]. D1: tx_shift <= rd_q, ptr++ -> RD_DATA.
//  rd_q <= mem[ptr] every cycle (sync read, 1-cycle latency); next word is therefore ready DATA_W-1 cycles early.
//  RD_DATA: MISO = tx_shift[DATA_W-1]; shift left each edge; on DATA_W-th bit tx_shift <= rd_q, ptr++ (wrap).
//  Read timing, ADDR_W=8: cmd cycles 0-7, addr 8-15, dummy 16-17, word0 MSB visible cycle 18..LSB 25, word1 26-33.
//  IGNORE: stay until SS_n high; no memory access; MISO 0.
//  frame_err: SS_n rise with bit_cnt != 0 in CMD/ADDR/WR_DATA (partial word discarded, no write). Not for RD_*.
//  SS_n rise exactly on a word boundary: clean end, no error. Reset mid-frame: IDLE next edge, partial write dropped.
//  Wrap: ptr DEPTH-1 + 1 -> 0 in both directions of burst; no error.
// STRUCTURE
//  Package spi_ram_pkg: CMD_WR=8'h02, CMD_RD=8'h03, CMD_W=8, RD_DUMMY_CYC=2, state enum.
//  Sub-module spi_ram_mem (DATA_W, DEPTH): one write port, registered read port; no reset on array.
//  Top holds FSM, bit counter, rx/tx shift registers, ptr.
// TESTING
//  Write 0x02,A=0x10,D=0xA5 then read 0x03,A=0x10 -> MISO 1010_0101 cycles 18-25, frame_err never.
//  Burst write 4 words 11,22,33,44 at 0x20; burst read 4 from 0x20 -> same order, back-to-back, no gap.
//  Burst write from DEPTH-1 (0xFF) two words 0x5A,0xC3; read 0x00 -> 0xC3 and 0xFF -> 0x5A (wrap).
//  Cmd 0x7E then 16 more bits -> frame_err pulse at cycle 8, MISO 0, memory unchanged.
//  SS_n high after 5 data bits of write to 0x30 -> frame_err 1 cycle, mem[0x30] keeps old value.
//  rst high mid-burst-read -> next cycle MISO 0, busy 0; new frame after rst works normally.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// -----------------------------------------------------------------------------
// spi_ram_pkg
// Shared command codes, field sizes and the frame FSM state type for the
// SPI-fronted burst RAM (spi_ram_burst).
// No ports: this package is imported by spi_ram_burst.
// -----------------------------------------------------------------------------
package spi_ram_pkg;

    localparam int         CMD_W        = 8;
    localparam logic [7:0] CMD_WR       = 8'h02;
    localparam logic [7:0] CMD_RD       = 8'h03;
    localparam int         RD_DUMMY_CYC = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD      = 3'd1,
        ST_ADDR     = 3'd2,
        ST_WR_DATA  = 3'd3,
        ST_RD_DUMMY = 3'd4,
        ST_RD_DATA  = 3'd5,
        ST_IGNORE   = 3'd6
    } state_e;

    // States in which the slave is assembling a field from MOSI; losing
    // SS_n part-way through one of these fields is a framing error.
    function automatic logic in_rx_field(input state_e s);
        logic r;
        case (s)
            ST_CMD, ST_ADDR, ST_WR_DATA: r = 1'b1;
            default:                     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/spi_ram_burst_if.sv
// -----------------------------------------------------------------------------
// spi_ram_burst_if
// SPI slave-side signal bundle for spi_ram_burst.
//   SS_n      master -> slave  slave select, active low
//   MOSI      master -> slave  serial data in, MSB first
//   MISO      slave  -> master serial data out, MSB first
//   busy      slave  -> master frame in progress
//   frame_err slave  -> master one-cycle framing/command error pulse
// -----------------------------------------------------------------------------
interface spi_ram_burst_if;

    logic SS_n;
    logic MOSI;
    logic MISO;
    logic busy;
    logic frame_err;

    modport master (
        output SS_n,
        output MOSI,
        input  MISO,
        input  busy,
        input  frame_err
    );

    modport slave (
        input  SS_n,
        input  MOSI,
        output MISO,
        output busy,
        output frame_err
    );

endinterface

// File: rtl/spi_ram_mem.sv
// -----------------------------------------------------------------------------
// spi_ram_mem
// Single-port storage array: one synchronous write port and a registered
// read port (one-cycle latency). The array itself has no reset so its
// contents survive a controller reset.
//   clk      in   clock
//   we       in   write enable
//   waddr    in   write address
//   wdata    in   write data
//   raddr    in   read address
//   rdata    out  registered read data (mem[raddr] of previous cycle)
// -----------------------------------------------------------------------------
module spi_ram_mem #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 256,
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port, updated every cycle.
    always_ff @(posedge clk) begin
        rdata <= mem_r[raddr];
    end

endmodule

// File: rtl/spi_ram_burst.sv
// -----------------------------------------------------------------------------
// spi_ram_burst
// SPI slave in front of a single-port RAM. A frame is an 8-bit command,
// an ADDR_W-bit start address, then any number of DATA_W-bit words until
// SS_n rises. Command 0x02 writes a burst, 0x03 reads a burst (two dummy
// cycles after the address); the word pointer auto-increments and wraps
// from DEPTH-1 to 0. Unknown commands and SS_n rising mid-field raise a
// one-cycle frame_err.
//   clk   in   clock; MOSI sampled and MISO updated on the rising edge
//   rst   in   synchronous active-high reset
//   bus   slave modport of spi_ram_burst_if (SS_n, MOSI, MISO, busy, frame_err)
// -----------------------------------------------------------------------------
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic           clk,
    input  logic           rst,
    spi_ram_burst_if.slave bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SH_W0 = (CMD_W > ADDR_W) ? CMD_W : ADDR_W;
    localparam int SH_W  = (SH_W0 > DATA_W) ? SH_W0 : DATA_W;
    localparam int CNT_W = $clog2(SH_W + 1);

    state_e            state_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [SH_W-2:0]   rx_shift_r;
    // Holds the not-yet-sent bits of the current read word; the MSB of
    // each word goes straight into miso_r when the word is loaded.
    logic [DATA_W-2:0] tx_shift_r;
    logic [PTR_W-1:0]  ptr_r;
    logic              is_rd_r;
    logic              miso_r;
    logic              busy_r;
    logic              frame_err_r;

    logic [SH_W-1:0]   rx_next_s;
    logic [PTR_W-1:0]  ptr_inc_s;
    logic [PTR_W-1:0]  ptr_load_s;
    logic              last_cmd_s;
    logic              last_addr_s;
    logic              last_data_s;
    logic              last_dummy_s;
    logic              wr_en_s;
    logic [DATA_W-1:0] wr_data_s;
    logic [DATA_W-1:0] rd_q_s;

    // Field assembly, pointer arithmetic and end-of-field detection.
    always_comb begin
        rx_next_s    = {rx_shift_r, bus.MOSI};
        ptr_inc_s    = (ptr_r == PTR_W'(DEPTH - 1)) ? '0 : ptr_r + PTR_W'(1);
        ptr_load_s   = PTR_W'(32'(rx_next_s[ADDR_W-1:0]) % 32'(DEPTH));
        last_cmd_s   = (bit_cnt_r == CNT_W'(CMD_W - 1));
        last_addr_s  = (bit_cnt_r == CNT_W'(ADDR_W - 1));
        last_data_s  = (bit_cnt_r == CNT_W'(DATA_W - 1));
        last_dummy_s = (bit_cnt_r == CNT_W'(RD_DUMMY_CYC - 1));
        wr_data_s    = rx_next_s[DATA_W-1:0];
    end

    // A word is committed only on the edge its final bit arrives with the
    // frame still selected and no reset; partial words are never written.
    always_comb begin
        wr_en_s = 1'b0;
        if (!rst && !bus.SS_n && (state_r == ST_WR_DATA) && last_data_s) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    spi_ram_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (wr_en_s),
        .waddr  (ptr_r),
        .wdata  (wr_data_s),
        .raddr  (ptr_r),
        .rdata  (rd_q_s)
    );

    // Frame FSM with counters, shift registers, pointer and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= '0;
            rx_shift_r  <= '0;
            tx_shift_r  <= '0;
            ptr_r       <= '0;
            is_rd_r     <= 1'b0;
            miso_r      <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else if (bus.SS_n) begin
            // Deselect ends any frame; it is an error only mid-field.
            frame_err_r <= in_rx_field(state_r) && (bit_cnt_r != '0);
            state_r     <= ST_IDLE;
            bit_cnt_r   <= '0;
            miso_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            busy_r      <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    rx_shift_r <= rx_next_s[SH_W-2:0];
                    bit_cnt_r  <= CNT_W'(1);
                    miso_r     <= 1'b0;
                    state_r    <= ST_CMD;
                end
                ST_CMD: begin
                    rx_shift_r <= rx_next_s[SH_W-2:0];
                    miso_r     <= 1'b0;
                    if (last_cmd_s) begin
                        bit_cnt_r <= '0;
                        if (rx_next_s[CMD_W-1:0] == CMD_WR) begin
                            is_rd_r <= 1'b0;
                            state_r <= ST_ADDR;
                        end else if (rx_next_s[CMD_W-1:0] == CMD_RD) begin
                            is_rd_r <= 1'b1;
                            state_r <= ST_ADDR;
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= ST_IGNORE;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end
                end
                ST_ADDR: begin
                    rx_shift_r <= rx_next_s[SH_W-2:0];
                    miso_r     <= 1'b0;
                    if (last_addr_s) begin
                        bit_cnt_r <= '0;
                        ptr_r     <= ptr_load_s;
                        state_r   <= is_rd_r ? ST_RD_DUMMY : ST_WR_DATA;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end
                end
                ST_WR_DATA: begin
                    rx_shift_r <= rx_next_s[SH_W-2:0];
                    miso_r     <= 1'b0;
                    if (last_data_s) begin
                        bit_cnt_r <= '0;
                        ptr_r     <= ptr_inc_s;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end
                end
                ST_RD_DUMMY: begin
                    // First dummy cycle lets rd_q settle on mem[ptr]; the
                    // second loads it and pre-advances the pointer.
                    if (last_dummy_s) begin
                        bit_cnt_r  <= '0;
                        miso_r     <= rd_q_s[DATA_W-1];
                        tx_shift_r <= rd_q_s[DATA_W-2:0];
                        ptr_r      <= ptr_inc_s;
                        state_r    <= ST_RD_DATA;
                    end else begin
                        bit_cnt_r  <= bit_cnt_r + CNT_W'(1);
                        miso_r     <= 1'b0;
                    end
                end
                ST_RD_DATA: begin
                    // rd_q already tracks the next word, so reloading on the
                    // last bit keeps words back-to-back with no gap.
                    if (last_data_s) begin
                        bit_cnt_r  <= '0;
                        miso_r     <= rd_q_s[DATA_W-1];
                        tx_shift_r <= rd_q_s[DATA_W-2:0];
                        ptr_r      <= ptr_inc_s;
                    end else begin
                        bit_cnt_r  <= bit_cnt_r + CNT_W'(1);
                        miso_r     <= tx_shift_r[DATA_W-2];
                        tx_shift_r <= tx_shift_r << 1;
                    end
                end
                ST_IGNORE: begin
                    miso_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bit_cnt_r <= '0;
                    miso_r    <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MISO      = miso_r;
    assign bus.busy      = busy_r;
    assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_ram_burst.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_burst
// Directed bench for spi_ram_burst (ADDR_W=8, DATA_W=8, DEPTH=256).
// Inputs change on the falling edge; index k of the logs holds what the
// DUT presents to rising edge k of the current frame (edge 0 = first edge
// with SS_n low).
// -----------------------------------------------------------------------------
module tb_spi_ram_burst;

    logic clk = 1'b0;
    logic rst;

    spi_ram_burst_if bus_if ();

    spi_ram_burst #(
        .ADDR_W (8),
        .DATA_W (8),
        .DEPTH  (256)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int   tests_run    = 0;
    int   tests_failed = 0;
    logic bits_q   [$];
    logic miso_log [$];
    logic ferr_log [$];

    task automatic push_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) bits_q.push_back(v[i]);
    endtask

    task automatic push_zeros(input int n);
        for (int i = 0; i < n; i++) bits_q.push_back(1'b0);
    endtask

    // Drive queued bits with SS_n low, logging MISO / frame_err per edge.
    task automatic drive_bits();
        miso_log.delete();
        ferr_log.delete();
        foreach (bits_q[i]) begin
            @(negedge clk);
            miso_log.push_back(bus_if.MISO);
            ferr_log.push_back(bus_if.frame_err);
            bus_if.MOSI = bits_q[i];
            bus_if.SS_n = 1'b0;
        end
        bits_q.delete();
    endtask

    // Raise SS_n for three edges, continuing the logs.
    task automatic end_frame();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            miso_log.push_back(bus_if.MISO);
            ferr_log.push_back(bus_if.frame_err);
            bus_if.SS_n = 1'b1;
            bus_if.MOSI = 1'b0;
        end
    endtask

    task automatic run_frame();
        drive_bits();
        end_frame();
    endtask

    task automatic read_frame(input logic [7:0] addr, input int nwords);
        push_byte(8'h03);
        push_byte(addr);
        push_zeros(2 + 8 * nwords);
        run_frame();
    endtask

    function automatic logic [7:0] log_word(input int start);
        logic [7:0] w;
        for (int i = 0; i < 8; i++) w[7 - i] = miso_log[start + i];
        return w;
    endfunction

    function automatic int count_ferr();
        int n = 0;
        foreach (ferr_log[i]) if (ferr_log[i] === 1'b1) n++;
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus_if.SS_n = 1'b1;
        bus_if.MOSI = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus_if.MISO !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_miso: got %b expected 0", bus_if.MISO);
        end
        tests_run++;
        if (bus_if.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b expected 0", bus_if.busy);
        end
        tests_run++;
        if (bus_if.frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ferr: got %b expected 0", bus_if.frame_err);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        logic [7:0] w;
        logic       any_dummy;
        push_byte(8'h02); push_byte(8'h10); push_byte(8'hA5);
        run_frame();
        tests_run++;
        if (count_ferr() != 0) begin
            tests_failed++;
            $display("FAIL single_wr_ferr: got %0d pulses expected 0", count_ferr());
        end
        tests_run++;
        if (bus_if.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_busy_end: got %b expected 0", bus_if.busy);
        end
        read_frame(8'h10, 1);
        w = log_word(18);
        tests_run++;
        if (w !== 8'hA5) begin
            tests_failed++;
            $display("FAIL single_rd_word: got %h expected a5", w);
        end
        any_dummy = miso_log[16] | miso_log[17];
        tests_run++;
        if (any_dummy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_dummy_miso: got %b expected 0", any_dummy);
        end
        tests_run++;
        if (miso_log[27] !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_miso_after: got %b expected 0", miso_log[27]);
        end
        tests_run++;
        if (count_ferr() != 0) begin
            tests_failed++;
            $display("FAIL single_rd_ferr: got %0d pulses expected 0", count_ferr());
        end
    endtask

    task automatic test_burst();
        logic [7:0] exp_w [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] w;
        push_byte(8'h02); push_byte(8'h20);
        for (int i = 0; i < 4; i++) push_byte(exp_w[i]);
        run_frame();
        tests_run++;
        if (count_ferr() != 0) begin
            tests_failed++;
            $display("FAIL burst_wr_ferr: got %0d pulses expected 0", count_ferr());
        end
        read_frame(8'h20, 4);
        for (int i = 0; i < 4; i++) begin
            w = log_word(18 + 8 * i);
            tests_run++;
            if (w !== exp_w[i]) begin
                tests_failed++;
                $display("FAIL burst_rd_word%0d: got %h expected %h", i, w, exp_w[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] w;
        push_byte(8'h02); push_byte(8'hFF); push_byte(8'h5A); push_byte(8'hC3);
        run_frame();
        read_frame(8'h00, 1);
        w = log_word(18);
        tests_run++;
        if (w !== 8'hC3) begin
            tests_failed++;
            $display("FAIL wrap_rd_00: got %h expected c3", w);
        end
        read_frame(8'hFF, 2);
        w = log_word(18);
        tests_run++;
        if (w !== 8'h5A) begin
            tests_failed++;
            $display("FAIL wrap_rd_ff: got %h expected 5a", w);
        end
        w = log_word(26);
        tests_run++;
        if (w !== 8'hC3) begin
            tests_failed++;
            $display("FAIL wrap_rd_burst: got %h expected c3", w);
        end
    endtask

    task automatic test_bad_cmd();
        logic       any_miso;
        logic [7:0] w;
        push_byte(8'h7E); push_byte(8'h10); push_byte(8'hFF);
        run_frame();
        tests_run++;
        if (ferr_log[8] !== 1'b1) begin
            tests_failed++;
            $display("FAIL badcmd_ferr_c8: got %b expected 1", ferr_log[8]);
        end
        tests_run++;
        if (count_ferr() != 1) begin
            tests_failed++;
            $display("FAIL badcmd_ferr_count: got %0d expected 1", count_ferr());
        end
        any_miso = 1'b0;
        foreach (miso_log[i]) any_miso = any_miso | miso_log[i];
        tests_run++;
        if (any_miso !== 1'b0) begin
            tests_failed++;
            $display("FAIL badcmd_miso: got %b expected 0", any_miso);
        end
        read_frame(8'h10, 1);
        w = log_word(18);
        tests_run++;
        if (w !== 8'hA5) begin
            tests_failed++;
            $display("FAIL badcmd_mem: got %h expected a5", w);
        end
    endtask

    task automatic test_partial_write();
        logic [7:0] w;
        push_byte(8'h02); push_byte(8'h30); push_byte(8'h3C);
        run_frame();
        push_byte(8'h02); push_byte(8'h30);
        for (int i = 0; i < 5; i++) bits_q.push_back(1'b1);
        run_frame();
        tests_run++;
        if (ferr_log[22] !== 1'b1) begin
            tests_failed++;
            $display("FAIL partial_ferr: got %b expected 1", ferr_log[22]);
        end
        tests_run++;
        if (count_ferr() != 1) begin
            tests_failed++;
            $display("FAIL partial_ferr_width: got %0d expected 1", count_ferr());
        end
        read_frame(8'h30, 1);
        w = log_word(18);
        tests_run++;
        if (w !== 8'h3C) begin
            tests_failed++;
            $display("FAIL partial_mem: got %h expected 3c", w);
        end
    endtask

    task automatic test_rst_mid();
        logic [7:0] w;
        push_byte(8'h03); push_byte(8'h20);
        push_zeros(12);
        drive_bits();
        w = log_word(18);
        tests_run++;
        if (w !== 8'h11) begin
            tests_failed++;
            $display("FAIL rstmid_word0: got %h expected 11", w);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus_if.MISO !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_miso: got %b expected 0", bus_if.MISO);
        end
        tests_run++;
        if (bus_if.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_busy: got %b expected 0", bus_if.busy);
        end
        rst = 1'b0;
        bus_if.SS_n = 1'b1;
        repeat (2) @(negedge clk);
        read_frame(8'h21, 2);
        w = log_word(18);
        tests_run++;
        if (w !== 8'h22) begin
            tests_failed++;
            $display("FAIL rstmid_after_w0: got %h expected 22", w);
        end
        w = log_word(26);
        tests_run++;
        if (w !== 8'h33) begin
            tests_failed++;
            $display("FAIL rstmid_after_w1: got %h expected 33", w);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_wrap();
        test_bad_cmd();
        test_partial_write();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
